// File: rtl/tl_src_pkg.sv
// Shared TileLink-UL opcodes, per-ID state encoding and mask helper for the
// single-beat request source.
package tl_src_pkg;

  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PART = 3'd1;
  localparam logic [2:0] GET      = 3'd4;
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;

  localparam int MASK_MAX_W = 128;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    PEND_A = 2'd1,
    WAIT_D = 2'd2
  } id_state_e;

  // Low `width` bits set; callers slice down to their own byte-lane count.
  function automatic logic [MASK_MAX_W-1:0] full_mask(input int unsigned width);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tl_src_id_pool.sv
// Source-ID pool: per-ID lifecycle, lowest-free allocation, D-source legality
// and a registered count of IDs in use.
module tl_src_id_pool
  import tl_src_pkg::*;
#(
  parameter int SRC_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_i,
  input  logic             alloc_write_i,
  input  logic             a_fire_i,
  input  logic [SRC_W-1:0] a_source_i,
  input  logic             d_fire_i,
  input  logic [SRC_W-1:0] d_source_i,
  output logic             any_free_o,
  output logic [SRC_W-1:0] alloc_id_o,
  output logic             d_legal_o,
  output logic             d_exp_write_o,
  output logic [SRC_W:0]   inflight_o
);

  localparam int NUM_SRC = 1 << SRC_W;

  id_state_e          state_q [NUM_SRC];
  id_state_e          state_d [NUM_SRC];
  logic [NUM_SRC-1:0] exp_write_q;
  logic [SRC_W:0]     busy_cnt;
  logic [SRC_W:0]     inflight_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    any_free_o = 1'b0;
    alloc_id_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin
        any_free_o = 1'b1;
        alloc_id_o = SRC_W'(i);
      end
    end
  end

  // Legality uses the registered state, so an ID whose A beat fires this same
  // cycle still looks PEND_A to the D side.
  assign d_legal_o     = (state_q[d_source_i] == WAIT_D);
  assign d_exp_write_o = exp_write_q[d_source_i];

  // The three transitions always land on distinct IDs (FREE, PEND_A, WAIT_D).
  always_comb begin
    state_d = state_q;
    if (alloc_i)                 state_d[alloc_id_o] = PEND_A;
    if (a_fire_i)                state_d[a_source_i] = WAIT_D;
    if (d_fire_i && d_legal_o)   state_d[d_source_i] = FREE;
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state_q[i] != FREE) busy_cnt = busy_cnt + {{SRC_W{1'b0}}, 1'b1};
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) state_q[i] <= FREE;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= busy_cnt;
    end
  end

  // NOTE: exp_write is deliberately not reset; it is only consulted for an ID
  // in WAIT_D, and reaching WAIT_D requires an allocation that writes it.
  always_ff @(posedge clock) begin
    if (alloc_i) exp_write_q[alloc_id_o] <= alloc_write_i;
  end

  assign inflight_o = inflight_q;

endmodule

// File: rtl/tl_a_req_source.sv
// TileLink-UL single-beat initiator: turns local commands into A-channel
// requests and D-channel beats into local responses.
module tl_a_req_source
  import tl_src_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_mask,
  output logic                a_valid,
  input  logic                a_ready,
  output logic [2:0]          a_opcode,
  output logic [1:0]          a_size,
  output logic [SRC_W-1:0]    a_source,
  output logic [ADDR_W-1:0]   a_address,
  output logic [DATA_W/8-1:0] a_mask,
  output logic [DATA_W-1:0]   a_data,
  input  logic                d_valid,
  output logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [SRC_W-1:0]    d_source,
  input  logic                d_denied,
  input  logic [DATA_W-1:0]   d_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SRC_W-1:0]    rsp_source,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [SRC_W:0]      inflight,
  output logic                proto_err
);

  localparam int                    STRB_W         = DATA_W / 8;
  localparam logic [MASK_MAX_W-1:0] MASK_ONES_WIDE = full_mask(STRB_W);
  localparam logic [STRB_W-1:0]     MASK_ONES      = MASK_ONES_WIDE[STRB_W-1:0];
  localparam logic [1:0]            A_SIZE         = 2'($clog2(STRB_W));

  logic              any_free, d_legal, d_exp_write;
  logic [SRC_W-1:0]  alloc_id;
  logic              cmd_fire, a_fire, d_fire, op_mismatch;
  logic [2:0]        exp_d_opcode;

  logic              a_valid_q;
  logic [2:0]        a_opcode_q, a_opcode_d;
  logic [1:0]        a_size_q;
  logic [SRC_W-1:0]  a_source_q;
  logic [ADDR_W-1:0] a_address_q;
  logic [STRB_W-1:0] a_mask_q, a_mask_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;

  logic              rsp_valid_q, rsp_err_q, proto_err_q;
  logic [SRC_W-1:0]  rsp_source_q;
  logic [DATA_W-1:0] rsp_data_q;

  assign cmd_ready = !reset && (!a_valid_q || a_ready) && any_free;
  assign d_ready   = !reset && (!rsp_valid_q || rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign a_fire    = a_valid_q && a_ready;
  assign d_fire    = d_valid && d_ready;

  tl_src_id_pool #(.SRC_W(SRC_W)) u_pool (
    .clock         (clock),
    .reset         (reset),
    .alloc_i       (cmd_fire),
    .alloc_write_i (cmd_write),
    .a_fire_i      (a_fire),
    .a_source_i    (a_source_q),
    .d_fire_i      (d_fire),
    .d_source_i    (d_source),
    .any_free_o    (any_free),
    .alloc_id_o    (alloc_id),
    .d_legal_o     (d_legal),
    .d_exp_write_o (d_exp_write),
    .inflight_o    (inflight)
  );

  always_comb begin
    a_opcode_d = GET;
    a_mask_d   = MASK_ONES;
    a_data_d   = '0;
    if (cmd_write) begin
      a_opcode_d = (cmd_mask == MASK_ONES) ? PUT_FULL : PUT_PART;
      a_mask_d   = cmd_mask;
      a_data_d   = cmd_data;
    end
  end

  // A new command can only load when the slot is empty or draining this cycle,
  // so a stalled request is never overwritten.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
    end else if (cmd_fire) begin
      a_valid_q   <= 1'b1;
      a_opcode_q  <= a_opcode_d;
      a_size_q    <= A_SIZE;
      a_source_q  <= alloc_id;
      a_address_q <= cmd_addr;
      a_mask_q    <= a_mask_d;
      a_data_q    <= a_data_d;
    end else if (a_fire) begin
      a_valid_q   <= 1'b0;
    end
  end

  assign exp_d_opcode = d_exp_write ? ACK : ACK_DATA;
  assign op_mismatch  = (d_opcode != exp_d_opcode);

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_source_q <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else if (d_fire && d_legal) begin
      rsp_valid_q  <= 1'b1;
      rsp_source_q <= d_source;
      rsp_data_q   <= (d_opcode == ACK_DATA) ? d_data : '0;
      rsp_err_q    <= d_denied | op_mismatch;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  // Sticky until reset: a beat for an ID not awaiting D, or a wrong opcode.
  always_ff @(posedge clock) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else if (d_fire && (!d_legal || op_mismatch)) begin
      proto_err_q <= 1'b1;
    end
  end

  assign a_valid    = a_valid_q;
  assign a_opcode   = a_opcode_q;
  assign a_size     = a_size_q;
  assign a_source   = a_source_q;
  assign a_address  = a_address_q;
  assign a_mask     = a_mask_q;
  assign a_data     = a_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_source = rsp_source_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_tl_a_req_source.sv
// Self-checking bench for tl_a_req_source: directed scenarios plus random
// traffic, all compared every cycle against a transaction-level model.
module tb_tl_a_req_source;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int SRC_W   = 2;
  localparam int STRB_W  = DATA_W / 8;
  localparam int NUM_SRC = 1 << SRC_W;

  localparam int M_FREE = 0;
  localparam int M_PEND = 1;
  localparam int M_WAIT = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_data;
  logic [STRB_W-1:0]   cmd_mask;
  logic                a_valid, a_ready;
  logic [2:0]          a_opcode;
  logic [1:0]          a_size;
  logic [SRC_W-1:0]    a_source;
  logic [ADDR_W-1:0]   a_address;
  logic [STRB_W-1:0]   a_mask;
  logic [DATA_W-1:0]   a_data;
  logic                d_valid, d_ready, d_denied;
  logic [2:0]          d_opcode;
  logic [SRC_W-1:0]    d_source;
  logic [DATA_W-1:0]   d_data;
  logic                rsp_valid, rsp_ready, rsp_err;
  logic [SRC_W-1:0]    rsp_source;
  logic [DATA_W-1:0]   rsp_data;
  logic [SRC_W:0]      inflight;
  logic                proto_err;

  tl_a_req_source #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
    .d_denied(d_denied), .d_data(d_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_source(rsp_source),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .inflight(inflight), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: ID lifecycle per source, one pending A request, one
  // buffered response, sticky error, and an in-use count that trails by a cycle.
  int          m_id   [NUM_SRC];
  bit          m_expw [NUM_SRC];
  bit          ma_valid;
  int unsigned ma_opcode, ma_size, ma_source, ma_mask;
  logic [ADDR_W-1:0] ma_addr;
  logic [DATA_W-1:0] ma_data;
  bit          mr_valid, mr_err;
  int unsigned mr_source;
  logic [DATA_W-1:0] mr_data;
  bit          m_perr;
  int unsigned m_infl;

  function automatic int m_lowest_free();
    for (int i = 0; i < NUM_SRC; i++) if (m_id[i] == M_FREE) return i;
    return -1;
  endfunction

  function automatic bit m_cmd_ready();
    return !reset && (!ma_valid || a_ready) && (m_lowest_free() >= 0);
  endfunction

  function automatic bit m_d_ready();
    return !reset && (!mr_valid || rsp_ready);
  endfunction

  task automatic model_reset();
    foreach (m_id[i]) begin m_id[i] = M_FREE; m_expw[i] = 1'b0; end
    ma_valid = 0; ma_opcode = 0; ma_size = 0; ma_source = 0; ma_mask = 0;
    ma_addr = '0; ma_data = '0;
    mr_valid = 0; mr_err = 0; mr_source = 0; mr_data = '0;
    m_perr = 0; m_infl = 0;
  endtask

  task automatic model_step();
    bit cf, af, df;
    int alloc, busy, ds, aid;
    int unsigned want_op;
    if (reset) begin model_reset(); return; end
    busy = 0;
    foreach (m_id[i]) if (m_id[i] != M_FREE) busy++;
    cf    = cmd_valid && m_cmd_ready();
    af    = ma_valid && a_ready;
    df    = d_valid && m_d_ready();
    alloc = m_lowest_free();
    ds    = int'(d_source);
    aid   = int'(ma_source);
    // D side judged against states as they stood before this edge.
    if (df && m_id[ds] == M_WAIT) begin
      want_op   = m_expw[ds] ? 0 : 1;
      mr_valid  = 1;
      mr_source = ds;
      mr_data   = (d_opcode == 3'd1) ? d_data : '0;
      mr_err    = d_denied || (int'(d_opcode) != want_op);
      if (int'(d_opcode) != want_op) m_perr = 1;
      m_id[ds]  = M_FREE;
    end else begin
      if (df) m_perr = 1;
      if (mr_valid && rsp_ready) mr_valid = 0;
    end
    if (af) m_id[aid] = M_WAIT;
    if (cf) begin
      m_id[alloc]   = M_PEND;
      m_expw[alloc] = cmd_write;
      ma_valid  = 1;
      ma_source = alloc;
      ma_size   = 2;
      ma_addr   = cmd_addr;
      if (cmd_write) begin
        ma_opcode = (cmd_mask == 4'hF) ? 0 : 1;
        ma_mask   = cmd_mask;
        ma_data   = cmd_data;
      end else begin
        ma_opcode = 4;
        ma_mask   = 4'hF;
        ma_data   = '0;
      end
    end else if (af) begin
      ma_valid = 0;
    end
    m_infl = busy;
  endtask

  task automatic check_outputs();
    check("cmd_ready",  cmd_ready,  m_cmd_ready());
    check("d_ready",    d_ready,    m_d_ready());
    check("a_valid",    a_valid,    ma_valid);
    check("a_opcode",   a_opcode,   ma_opcode);
    check("a_size",     a_size,     ma_size);
    check("a_source",   a_source,   ma_source);
    check("a_address",  a_address,  ma_addr);
    check("a_mask",     a_mask,     ma_mask);
    check("a_data",     a_data,     ma_data);
    check("rsp_valid",  rsp_valid,  mr_valid);
    check("rsp_source", rsp_source, mr_source);
    check("rsp_data",   rsp_data,   mr_data);
    check("rsp_err",    rsp_err,    mr_err);
    check("inflight",   inflight,   m_infl);
    check("proto_err",  proto_err,  m_perr);
  endtask

  // Inputs are driven at posedge+1; outputs are compared at the falling edge.
  task automatic cycle();
    @(negedge clock);
    check_outputs();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    a_ready = 0; d_valid = 0; d_opcode = '0; d_source = '0; d_denied = 0;
    d_data = '0; rsp_ready = 1;
  endtask

  task automatic do_reset();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic issue(input bit wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] mask);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
  endtask

  task automatic drain();
    cmd_valid = 0; a_ready = 1; rsp_ready = 1;
    repeat (2) cycle();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (m_id[i] == M_WAIT) begin
        d_valid = 1; d_source = SRC_W'(i); d_opcode = m_expw[i] ? 3'd0 : 3'd1;
        d_denied = 0; d_data = $urandom;
        cycle();
      end
    end
    d_valid = 0;
    repeat (2) cycle();
  endtask

  initial begin
    int waits[$];
    idle_inputs();
    model_reset();
    reset = 1;
    #1;
    check("rst_cmd_ready_low", cmd_ready, 0);
    check("rst_d_ready_low", d_ready, 0);
    cycle(); cycle();
    reset = 0;
    cycle();
    check("rst_inflight", inflight, 0);
    check("rst_a_valid", a_valid, 0);

    // Single read, response with data.
    issue(0, 32'h1000, '0, '0); a_ready = 1;
    cycle();
    cmd_valid = 0;
    check("t1_a_valid", a_valid, 1);
    check("t1_opcode", a_opcode, 4);
    check("t1_source", a_source, 0);
    check("t1_mask", a_mask, 4'hF);
    cycle();
    d_valid = 1; d_source = 0; d_opcode = 3'd1; d_data = 32'hDEAD_BEEF;
    cycle();
    d_valid = 0;
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_data", rsp_data, 32'hDEAD_BEEF);
    check("t1_rsp_err", rsp_err, 0);
    repeat (2) cycle();
    check("t1_inflight_zero", inflight, 0);

    // Partial write stalled by a_ready low for 5 cycles.
    issue(1, 32'h2004, 32'hCAFE_0123, 4'h3); a_ready = 0;
    cycle();
    cmd_valid = 0;
    repeat (5) begin
      check("t2_a_valid_held", a_valid, 1);
      check("t2_opcode", a_opcode, 1);
      check("t2_mask_held", a_mask, 4'h3);
      cycle();
    end
    a_ready = 1;
    cycle();
    check("t2_single_fire", a_valid, 0);
    d_valid = 1; d_source = 0; d_opcode = 3'd0; d_data = 32'h5555_AAAA;
    cycle();
    d_valid = 0;
    check("t2_rsp_data_zero", rsp_data, 0);
    check("t2_rsp_err", rsp_err, 0);
    cycle();

    // Exhaust all IDs, then retire ID 2 and reuse it one cycle later.
    issue(0, 32'h3000, '0, '0); a_ready = 1;
    for (int k = 0; k < NUM_SRC; k++) begin
      cycle();
      check($sformatf("t3_src_order%0d", k), a_source, k);
    end
    cmd_valid = 0;
    repeat (2) cycle();
    check("t3_inflight_full", inflight, NUM_SRC);
    check("t3_cmd_ready_low", cmd_ready, 0);
    cmd_valid = 1;
    d_valid = 1; d_source = 2; d_opcode = 3'd1; d_data = 32'h0000_0222;
    #1;
    check("t3_no_same_cycle_reuse", cmd_ready, 0);
    cycle();
    d_valid = 0;
    check("t3_reuse_ready", cmd_ready, 1);
    cycle();
    cmd_valid = 0;
    check("t3_reuse_src", a_source, 2);
    check("t3_reuse_valid", a_valid, 1);
    drain();

    // D on a FREE ID, then write answered with AccessAckData.
    d_valid = 1; d_source = 3; d_opcode = 3'd0;
    cycle();
    d_valid = 0;
    check("t4_proto_err", proto_err, 1);
    check("t4_no_rsp", rsp_valid, 0);
    repeat (3) cycle();
    check("t4_proto_sticky", proto_err, 1);
    do_reset();
    check("t4_proto_cleared", proto_err, 0);
    issue(1, 32'h4000, 32'h1111_2222, 4'hF); a_ready = 1;
    cycle();
    cmd_valid = 0;
    check("t4_put_full", a_opcode, 0);
    cycle();
    d_valid = 1; d_source = 0; d_opcode = 3'd1; d_data = 32'h1234;
    cycle();
    d_valid = 0;
    check("t4_rsp_err", rsp_err, 1);
    check("t4_mismatch_proto", proto_err, 1);
    cycle();

    // Response backpressure with two beats queued.
    do_reset();
    issue(0, 32'h5000, '0, '0); a_ready = 1;
    repeat (2) cycle();
    cmd_valid = 0;
    cycle();
    rsp_ready = 0;
    d_valid = 1; d_source = 0; d_opcode = 3'd1; d_data = 32'hA0A0_A0A0;
    cycle();
    d_source = 1; d_data = 32'hB1B1_B1B1;
    check("t5_d_ready_blocked", d_ready, 0);
    repeat (2) cycle();
    check("t5_rsp_held", rsp_source, 0);
    rsp_ready = 1;
    cycle();
    d_valid = 0;
    check("t5_second_rsp_src", rsp_source, 1);
    check("t5_second_rsp_data", rsp_data, 32'hB1B1_B1B1);
    cycle();

    // Reset with three IDs in flight.
    do_reset();
    issue(0, 32'h6000, '0, '0); a_ready = 1;
    repeat (3) cycle();
    cmd_valid = 0;
    cycle();
    do_reset();
    check("t6_a_valid", a_valid, 0);
    check("t6_a_opcode", a_opcode, 0);
    check("t6_a_address", a_address, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_inflight", inflight, 0);
    issue(0, 32'h7000, '0, '0);
    cycle();
    cmd_valid = 0;
    check("t6_src0_after_reset", a_source, 0);
    cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      cmd_valid = $urandom_range(0, 1);
      cmd_write = $urandom_range(0, 1);
      cmd_addr  = $urandom;
      cmd_data  = $urandom;
      cmd_mask  = ($urandom_range(0, 1) == 1) ? 4'hF : STRB_W'($urandom);
      a_ready   = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      d_valid   = $urandom_range(0, 1);
      waits.delete();
      foreach (m_id[i]) if (m_id[i] == M_WAIT) waits.push_back(i);
      if (waits.size() > 0 && $urandom_range(0, 9) != 0)
        d_source = SRC_W'(waits[$urandom_range(0, waits.size() - 1)]);
      else
        d_source = SRC_W'($urandom_range(0, NUM_SRC - 1));
      d_opcode = m_expw[d_source] ? 3'd0 : 3'd1;
      if ($urandom_range(0, 9) == 0) d_opcode = d_opcode ^ 3'd1;
      d_denied = ($urandom_range(0, 9) == 0);
      d_data   = $urandom;
      cycle();
    end
    reset = 0;
    idle_inputs();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tl_a_req_source.md
Name: tl_a_req_source

Overview:
- Initiator (master) end of a single-beat TileLink-UL link.
- Takes local read/write commands, allocates a source ID, and drives the A channel.
- Accepts D-channel responses, retires the IDs, and returns responses to the local side.
- Sits between a local command port and the TL crossbar. It must never violate the A/D handshake rules that the crossbar-side assertion monitors check.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (single beat; a_size fixed to log2(DATA_W/8))
SRC_W, 2, source ID width; NUM_SRC = 2**SRC_W outstanding requests max

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  local command valid
cmd_ready  out  1  local command accepted this cycle when both high
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_data  in  DATA_W  write data
cmd_mask  in  DATA_W/8  byte enables (writes only)
a_valid  out  1  A channel valid
a_ready  in  1  A channel ready
a_opcode  out  3  0 PutFullData, 1 PutPartialData, 4 Get
a_size  out  2  log2(DATA_W/8)
a_source  out  SRC_W  allocated ID
a_address  out  ADDR_W  request address
a_mask  out  DATA_W/8  byte mask
a_data  out  DATA_W  write data
d_valid  in  1  D channel valid
d_ready  out  1  D channel ready
d_opcode  in  3  0 AccessAck, 1 AccessAckData
d_source  in  SRC_W  responding ID
d_denied  in  1  slave error
d_data  in  DATA_W  read data
rsp_valid  out  1  local response valid
rsp_ready  in  1  local response ready
rsp_source  out  SRC_W  ID being retired
rsp_data  out  DATA_W  read data; 0 for writes
rsp_err  out  1  denied or opcode mismatch
inflight  out  SRC_W+1  count of non-FREE IDs
proto_err  out  1  sticky protocol violation flag

Behaviour:
- Reset: one clock, sync active-high. Every output is 0. All IDs go FREE and proto_err clears. Outstanding transactions are silently dropped. cmd_ready and d_ready stay 0 while reset is high.
- Per-ID state: FREE -> PEND_A -> WAIT_D -> FREE. Each ID also stores an exp_write bit.
- cmd_ready = !reset && (!a_valid || a_ready) && (any ID FREE).
- Command fire:
  - The lowest-index FREE ID moves to PEND_A and records exp_write = cmd_write.
  - The A register loads next cycle, so a_valid rises 1 cycle after the cmd fire.
  - Back-to-back issue is allowed when a_ready is high.
- Opcode: write with mask all ones -> 0. Write with partial mask -> 1. Read -> 4 with a_mask all ones. a_data = 0 for Get.
- A stability: while a_valid && !a_ready, every a_* output holds its value. a_valid never drops without a fire.
- A fire moves the a_source ID PEND_A -> WAIT_D. a_valid clears unless a new cmd fires in the same cycle.
- d_ready = !reset && (!rsp_valid || rsp_ready). The response buffer is a single entry; rsp_* latch 1 cycle after D fire.
- D fire on a WAIT_D ID:
  - The ID goes FREE.
  - rsp_data = d_data if d_opcode = 1, else 0.
  - rsp_err = d_denied | (d_opcode != expected). Expected is 0 when exp_write = 1, 1 when exp_write = 0.
  - On opcode mismatch, proto_err is also set.
- D fire on a FREE or PEND_A ID (response before request accepted): set proto_err, drop the beat (no rsp_valid), leave the ID state unchanged.
- Same-cycle free and allocate: allocation sees the pre-free state. A freed ID is reusable the next cycle, never the same cycle.
- Same-cycle A fire and D fire on the same ID: the D beat is treated as PEND_A, so proto_err is set.
- All FREE IDs exhausted (inflight = NUM_SRC): cmd_ready = 0 until a D fire retires an ID.
- inflight is a registered popcount of non-FREE IDs, updated the cycle after each transition.

Decomposition:
- Package tl_src_pkg holds:
  - opcode localparams: PUT_FULL = 0, PUT_PART = 1, GET = 4, ACK = 0, ACK_DATA = 1;
  - enum id_state_e {FREE, PEND_A, WAIT_D};
  - function full_mask(width).
- Sub-module tl_src_id_pool holds the per-ID state and exp_write array, the lowest-free priority encoder, any_free, popcount and the legality check for an incoming d_source.
- Top level holds the A register, the response buffer and the proto_err flag.

Test Plan:
- Read at 0x1000, a_ready = 1, then D AccessAckData source 0 with data 0xDEADBEEF -> a_valid at cycle+1 with opcode 4, source 0, mask 0xF; rsp_data = 0xDEADBEEF, rsp_err = 0, inflight returns to 0.
- Write with mask 0x3 while a_ready is held low 5 cycles -> opcode 1, a_* stable all 5 cycles, single fire; AccessAck gives rsp_data = 0.
- Issue 4 reads with no D responses -> sources 0, 1, 2, 3 in order, inflight = 4, cmd_ready = 0. One D on source 2 -> next command gets source 2 one cycle later, not in the same cycle.
- D on a FREE source 3 -> proto_err = 1 and stays set, no rsp_valid. Write answered with AccessAckData -> rsp_err = 1 and proto_err = 1.
- rsp_ready held at 0 with 2 D beats pending -> d_ready = 0 after the first beat; the second beat is accepted 1 cycle after rsp_ready rises.
- Reset with 3 IDs in flight -> next cycle all outputs 0, inflight = 0. A new command gets source 0.
